sfft_run_ctrl: RTL and testbench
================================

Name: sfft_run_ctrl

Overview:
Run sequencer for the stochastic-bitstream FFT array. On a start request it clears the butterfly state, loads twiddle factors, and enables the array for one full bitstream period plus pipeline latency. It counts the ones on every real/imag output stream into binary results, then reports done. It sits between the host/register interface and the FFT datapath's iEn/loadW/iClr controls.

Parameters:
BITWIDTH, 8, precision; bitstream length is 2**BITWIDTH cycles
NUMINPUTS, 2, FFT points; width of the output bitstream buses from the array
LATENCY, 1, clock cycles from iEn to the first valid output bit of the array (0..15)

Ports:
iClk  in  1  clock, rising edge
iRstN  in  1  asynchronous active-low reset
iStart  in  1  run request; sampled only in IDLE
iAbort  in  1  cancel the current run
iReal  in  NUMINPUTS  real output bitstreams from the array
iImg  in  NUMINPUTS  imaginary output bitstreams from the array
oEn  out  1  array enable
oLoadW  out  1  twiddle load strobe to the array
oClr  out  1  array clear strobe
oBusy  out  1  high in every state except IDLE
oDone  out  1  one-cycle completion pulse
oCntReal  out  NUMINPUTS*(BITWIDTH+1)  per-point ones count; point n at [n*(BITWIDTH+1) +: BITWIDTH+1]
oCntImg  out  NUMINPUTS*(BITWIDTH+1)  same packing, imaginary

Behaviour:
- All outputs are registered and Moore-decoded from state. On reset all outputs are 0, state is IDLE, and the cycle counter and counts are 0.
- FSM states: IDLE, CLR, LOAD, RUN, DONE.
- IDLE: go to CLR on iStart=1 and iAbort=0. iStart asserted while not in IDLE is ignored.
- CLR: one cycle. oClr=1. Counts are zeroed. Go to LOAD.
- LOAD: one cycle. oLoadW=1. Go to RUN.
- RUN: oEn=1 for exactly 2**BITWIDTH+LATENCY cycles. The run counter k counts 0..2**BITWIDTH+LATENCY-1.
  - For each n, when k>=LATENCY, add iReal[n] to the real count and iImg[n] to the imag count.
  - After the last k, go to DONE.
- DONE: one cycle. oDone=1, oEn=0. Go to IDLE.
- Counts hold their value from DONE until the next CLR.
- Count width is BITWIDTH+1, so an all-ones stream gives exactly 2**BITWIDTH with no wrap. The run counter width is sized to hold 2**BITWIDTH+LATENCY-1.
- Timing: iStart seen at edge 0 gives CLR at 1, LOAD at 2, RUN at 3..2+2**BITWIDTH+LATENCY, and DONE at 3+2**BITWIDTH+LATENCY.
- iAbort=1 in CLR, LOAD or RUN: next state is IDLE, all strobes drop, counts are zeroed, and no oDone pulse occurs.
- iAbort in DONE is ignored; the pulse completes.
- iStart and iAbort both high in IDLE: abort wins and the FSM stays IDLE.
- Reset mid-run: immediate asynchronous return to IDLE with all outputs 0.

Optional Feature:
SFFT_CTRL_CONT_EN
- Defined: DONE goes directly to CLR (not IDLE) when iStart=1 and iAbort=0 in DONE, giving back-to-back runs with oBusy held high. The oDone pulse still fires once per run.
- Counts are valid only during the DONE cycle, because the next CLR zeroes them.
- Undefined: DONE always returns to IDLE, and a new run needs iStart seen in IDLE.

Test Plan:
- Sequence and timing, BITWIDTH=4, LATENCY=1. Pulse iStart at edge 0 -> oClr high for cycle 1 only; oLoadW high for cycle 2 only; oEn high for cycles 3..19 (17 cycles); oDone high for cycle 20 only; oBusy falls at 21.
- All-ones input, NUMINPUTS=2. iReal=2'b11, iImg=2'b00 throughout -> at DONE oCntReal = {5'd16, 5'd16} and oCntImg = 0.
- Latency window, LATENCY=2. iReal[0]=1 only during RUN k=0,1 and 0 afterwards -> oCntReal[0] = 0.
  - Then iReal[0]=1 only at k=17 (the last cycle) -> count = 1.
- Abort at RUN k=5 -> next cycle IDLE, oEn=0, no oDone, counts = 0. iStart 3 cycles later gives a normal full run.
- Priority and ignore rules.
  - iStart and iAbort high together in IDLE -> stays IDLE.
  - iStart pulsed during RUN -> no effect on the timing above.
  - iRstN low at RUN k=8 -> all outputs 0 asynchronously, without waiting for a clock edge.
- SFFT_CTRL_CONT_EN defined, iStart held high -> DONE is followed immediately by CLR, oBusy never drops, oDone pulses every 20 cycles (BITWIDTH=4, LATENCY=1).

Source files
------------

// File: rtl/sfft_run_ctrl.sv
// sfft_run_ctrl: run sequencer for the stochastic FFT array (clear, twiddle load, enable, ones counting).
// Optional SFFT_CTRL_CONT_EN: a start request seen in DONE chains straight into the next run.
module sfft_run_ctrl #(
  parameter int BITWIDTH  = 8,
  parameter int NUMINPUTS = 2,
  parameter int LATENCY   = 1
) (
  input  logic                                iClk,
  input  logic                                iRstN,
  input  logic                                iStart,
  input  logic                                iAbort,
  input  logic [NUMINPUTS-1:0]                iReal,
  input  logic [NUMINPUTS-1:0]                iImg,
  output logic                                oEn,
  output logic                                oLoadW,
  output logic                                oClr,
  output logic                                oBusy,
  output logic                                oDone,
  output logic [NUMINPUTS*(BITWIDTH+1)-1:0]   oCntReal,
  output logic [NUMINPUTS*(BITWIDTH+1)-1:0]   oCntImg
);
  localparam int CW      = BITWIDTH + 1;
  localparam int RUN_LEN = (1 << BITWIDTH) + LATENCY;
  localparam int KW      = $clog2(RUN_LEN);
  typedef enum logic [2:0] {IDLE, CLR, LOAD, RUN, DONE} state_t;
  state_t state, nxt;
  logic [KW-1:0] k;
  logic last, go, cnt_clr;
  assign last = k == KW'(RUN_LEN - 1);
  assign go   = iStart && !iAbort;
  always_comb begin
    nxt = state;
    if (state == IDLE)
      nxt = go ? CLR : IDLE;
    else if (state == DONE)
`ifdef SFFT_CTRL_CONT_EN
      nxt = go ? CLR : IDLE;
`else
      nxt = IDLE;
`endif
    else if (iAbort)
      nxt = IDLE;
    else
      nxt = state == CLR ? LOAD : state == LOAD ? RUN : last ? DONE : RUN;
  end
  // Only an abort can take CLR/LOAD/RUN back to IDLE, and an abort discards the counts.
  assign cnt_clr = nxt == CLR || (state inside {CLR, LOAD, RUN} && nxt == IDLE);
  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state    <= IDLE;
      k        <= '0;
      oEn      <= 1'b0;
      oLoadW   <= 1'b0;
      oClr     <= 1'b0;
      oBusy    <= 1'b0;
      oDone    <= 1'b0;
      oCntReal <= '0;
      oCntImg  <= '0;
    end else begin
      state  <= nxt;
      oClr   <= nxt == CLR;
      oLoadW <= nxt == LOAD;
      oEn    <= nxt == RUN;
      oDone  <= nxt == DONE;
      oBusy  <= nxt != IDLE;
      k      <= (state == RUN && nxt == RUN) ? k + 1'b1 : '0;
      if (cnt_clr) begin
        oCntReal <= '0;
        oCntImg  <= '0;
      end else if (state == RUN && k >= KW'(LATENCY)) begin
        for (int n = 0; n < NUMINPUTS; n++) begin
          oCntReal[n*CW +: CW] <= oCntReal[n*CW +: CW] + CW'(iReal[n]);
          oCntImg[n*CW +: CW]  <= oCntImg[n*CW +: CW] + CW'(iImg[n]);
        end
      end
    end
  end
endmodule

// File: tb/tb_sfft_run_ctrl.sv
// tb_sfft_run_ctrl: directed checks of sfft_run_ctrl with BITWIDTH=4 at LATENCY=1 (u_a) and LATENCY=2 (u_b).
module tb_sfft_run_ctrl;
  localparam int BW = 4;
  localparam int NI = 2;
  localparam int CW = BW + 1;
  logic clk = 1'b0, rst_n = 1'b0, start_a = 1'b0, start_b = 1'b0, abort = 1'b0;
  logic [NI-1:0] re = '0, im = '0;
  logic en_a, load_a, clr_a, busy_a, done_a, en_b, load_b, clr_b, busy_b, done_b;
  logic [NI*CW-1:0] cr_a, ci_a, cr_b, ci_b;
  logic [4:0] ctl_a;
  int vectors = 0, miscompares = 0;
  always #5 clk = ~clk;
  assign ctl_a = {clr_a, load_a, en_a, done_a, busy_a};
  sfft_run_ctrl #(.BITWIDTH(BW), .NUMINPUTS(NI), .LATENCY(1)) u_a (
    .iClk(clk), .iRstN(rst_n), .iStart(start_a), .iAbort(abort), .iReal(re), .iImg(im),
    .oEn(en_a), .oLoadW(load_a), .oClr(clr_a), .oBusy(busy_a), .oDone(done_a),
    .oCntReal(cr_a), .oCntImg(ci_a));
  sfft_run_ctrl #(.BITWIDTH(BW), .NUMINPUTS(NI), .LATENCY(2)) u_b (
    .iClk(clk), .iRstN(rst_n), .iStart(start_b), .iAbort(abort), .iReal(re), .iImg(im),
    .oEn(en_b), .oLoadW(load_b), .oClr(clr_b), .oBusy(busy_b), .oDone(done_b),
    .oCntReal(cr_b), .oCntImg(ci_b));
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  // Expected {clr, loadw, en, done, busy} of u_a in cycle c of a run started at cycle 0.
  function automatic logic [4:0] exp_a(input int c);
    return {c == 1, c == 2, c >= 3 && c <= 19, c == 20, c >= 1 && c <= 20};
  endfunction
  task automatic test_reset;
    #2;
    vectors++;
    if ({ctl_a, cr_a, ci_a, en_b, load_b, clr_b, busy_b, done_b, cr_b, ci_b} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs got a=%b/%h/%h b=%b%b%b%b%b want all zero", ctl_a, cr_a, ci_a, clr_b, load_b, en_b, done_b, busy_b);
    end
    tick;
    rst_n = 1'b1;
    tick;
    vectors++;
    if (ctl_a !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_idle got %b want 00000", ctl_a);
    end
  endtask
  task automatic test_sequence;
    logic [NI*CW-1:0] full = {5'd16, 5'd16};
    re = 2'b11;
    im = 2'b00;
    start_a = 1'b1;
    tick;
    start_a = 1'b0;
    for (int c = 1; c <= 21; c++) begin
      vectors++;
      if (ctl_a !== exp_a(c)) begin
        miscompares++;
        $display("FAIL seq_ctl c=%0d got %b want %b", c, ctl_a, exp_a(c));
      end
      if (c >= 20) begin
        vectors++;
        if (cr_a !== full || ci_a !== '0) begin
          miscompares++;
          $display("FAIL seq_counts c=%0d got real=%h img=%h want real=%h img=0", c, cr_a, ci_a, full);
        end
      end
      tick;
    end
  endtask
  task automatic test_latency;
    im = 2'b00;
    for (int r = 0; r < 2; r++) begin
      int lo = r ? 17 : 0;
      int hi = r ? 17 : 1;
      re = 2'b00;
      start_b = 1'b1;
      tick;
      start_b = 1'b0;
      for (int c = 1; c <= 21; c++) begin
        int k = c - 3;
        vectors++;
        if ({en_b, done_b} !== {c >= 3 && c <= 20, c == 21}) begin
          miscompares++;
          $display("FAIL lat_ctl r=%0d c=%0d got en=%b done=%b want en=%b done=%b", r, c, en_b, done_b, c >= 3 && c <= 20, c == 21);
        end
        if (c == 21) begin
          vectors++;
          if (cr_b !== {5'd0, 5'(r)} || ci_b !== '0) begin
            miscompares++;
            $display("FAIL lat_count r=%0d got real=%h img=%h want real=%h img=0", r, cr_b, ci_b, {5'd0, 5'(r)});
          end
        end
        re = {1'b0, c >= 3 && k >= lo && k <= hi};
        tick;
      end
      re = 2'b00;
    end
  endtask
  task automatic test_abort;
    re = 2'b11;
    start_a = 1'b1;
    tick;
    start_a = 1'b0;
    for (int c = 1; c < 8; c++) tick;
    vectors++;
    if (!en_a || cr_a !== {5'd4, 5'd4}) begin
      miscompares++;
      $display("FAIL abort_pre got en=%b real=%h want en=1 real=%h", en_a, cr_a, {5'd4, 5'd4});
    end
    abort = 1'b1;
    tick;
    abort = 1'b0;
    vectors++;
    if (ctl_a !== 5'b0 || cr_a !== '0 || ci_a !== '0) begin
      miscompares++;
      $display("FAIL abort_idle got ctl=%b real=%h img=%h want all zero", ctl_a, cr_a, ci_a);
    end
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (done_a !== 1'b0 || busy_a !== 1'b0) begin
        miscompares++;
        $display("FAIL abort_quiet i=%0d got done=%b busy=%b want 0 0", i, done_a, busy_a);
      end
      tick;
    end
    start_a = 1'b1;
    tick;
    start_a = 1'b0;
    for (int c = 1; c <= 21; c++) begin
      vectors++;
      if (ctl_a !== exp_a(c)) begin
        miscompares++;
        $display("FAIL abort_rerun c=%0d got %b want %b", c, ctl_a, exp_a(c));
      end
      if (c == 20) begin
        vectors++;
        if (cr_a !== {5'd16, 5'd16}) begin
          miscompares++;
          $display("FAIL abort_rerun_count got %h want %h", cr_a, {5'd16, 5'd16});
        end
      end
      tick;
    end
  endtask
  task automatic test_priority;
    start_a = 1'b1;
    abort = 1'b1;
    tick;
    start_a = 1'b0;
    abort = 1'b0;
    vectors++;
    if (ctl_a !== 5'b0) begin
      miscompares++;
      $display("FAIL prio_abort_wins got %b want 00000", ctl_a);
    end
    start_a = 1'b1;
    tick;
    start_a = 1'b0;
    for (int c = 1; c <= 21; c++) begin
      vectors++;
      if (ctl_a !== exp_a(c)) begin
        miscompares++;
        $display("FAIL prio_start_in_run c=%0d got %b want %b", c, ctl_a, exp_a(c));
      end
      start_a = c == 10;
      tick;
    end
    vectors++;
    if (busy_a !== 1'b0) begin
      miscompares++;
      $display("FAIL prio_no_restart got busy=%b want 0", busy_a);
    end
  endtask
  task automatic test_reset_midrun;
    re = 2'b11;
    start_a = 1'b1;
    tick;
    start_a = 1'b0;
    for (int c = 1; c < 11; c++) tick;
    vectors++;
    if (!en_a || cr_a !== {5'd7, 5'd7}) begin
      miscompares++;
      $display("FAIL rst_pre got en=%b real=%h want en=1 real=%h", en_a, cr_a, {5'd7, 5'd7});
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (ctl_a !== 5'b0 || cr_a !== '0 || ci_a !== '0) begin
      miscompares++;
      $display("FAIL rst_async got ctl=%b real=%h img=%h want all zero", ctl_a, cr_a, ci_a);
    end
    #2 rst_n = 1'b1;
    tick;
    vectors++;
    if (busy_a !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_after got busy=%b want 0", busy_a);
    end
  endtask
  task automatic test_back_to_back;
    int guard = 0;
    start_a = 1'b1;
    tick;
`ifdef SFFT_CTRL_CONT_EN
    for (int c = 1; c <= 45; c++) begin
      vectors++;
      if ({busy_a, done_a, clr_a} !== {1'b1, c == 20 || c == 40, c == 1 || c == 21 || c == 41}) begin
        miscompares++;
        $display("FAIL b2b_cont c=%0d got busy=%b done=%b clr=%b want 1 %b %b", c, busy_a, done_a, clr_a, c == 20 || c == 40, c == 1 || c == 21 || c == 41);
      end
      tick;
    end
`else
    for (int c = 1; c <= 22; c++) begin
      vectors++;
      if ({busy_a, done_a, clr_a} !== {c != 21, c == 20, c == 1 || c == 22}) begin
        miscompares++;
        $display("FAIL b2b_single c=%0d got busy=%b done=%b clr=%b want %b %b %b", c, busy_a, done_a, clr_a, c != 21, c == 20, c == 1 || c == 22);
      end
      tick;
    end
`endif
    start_a = 1'b0;
    while (busy_a && guard < 60) begin
      guard++;
      tick;
    end
    vectors++;
    if (busy_a !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_drain got busy=%b after %0d cycles want 0", busy_a, guard);
    end
  endtask
  initial begin
    test_reset;
    test_sequence;
    test_latency;
    test_abort;
    test_priority;
    test_reset_midrun;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
